bidir_responder: RTL and testbench

Half-duplex single-wire responder for a bidirectional pad driven through an ECP5 `BB` primitive. It listens while the remote initiator drives the shared line and receives one framed byte. After a fixed turnaround it drives one queued reply byte back on the same wire, then releases the line. It is the far-end counterpart to an initiator that tristates its own `BB` to listen, and it sits between a top-level `inout` pin and fabric logic that consumes commands and supplies replies.

---
 rtl/bidir_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_bidir_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_responder.sv
// Purpose : half-duplex single-wire responder; receives one framed byte, then replies with one queued byte on the same pad.
// Latency : rx_valid one cycle after the stop sample; reply start bit TURNAROUND_BITS*CLOCKS_PER_BIT cycles after the stop sample.
// Backpr. : one-entry reply holding register; tx_ready low while it is full, the line itself has no flow control.
//
// Ports:
//   clock, reset         sole clock (rising edge), asynchronous active-high reset
//   line                 shared wire, externally pulled high (tristate pad buffer)
//   rx_data/rx_valid     last good byte and its one-cycle strobe
//   frame_error          one-cycle strobe when the stop bit was sampled low
//   tx_data/tx_valid/tx_ready  reply byte handshake into the holding register
//   busy                 high while this block drives line
module bidir_responder #(
    parameter int CLOCKS_PER_BIT  = 12,   // >= 4
    parameter int TURNAROUND_BITS = 2     // >= 1
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int HALF     = CLOCKS_PER_BIT / 2;
    localparam int TURN_CYC = TURNAROUND_BITS * CLOCKS_PER_BIT;
    localparam int CNT_MAX  = (TURN_CYC > CLOCKS_PER_BIT) ? TURN_CYC : CLOCKS_PER_BIT;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    // The TURN state is entered one cycle after the stop sample and the
    // decision is registered, so the last TURN count is two short of the
    // full turnaround; that puts the first driven cycle exactly TURN_CYC
    // cycles after the stop sample.
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_START,
        ST_RX_DATA,
        ST_RX_STOP,
        ST_TURN,
        ST_TX_START,
        ST_TX_DATA,
        ST_TX_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_frame_error;
    logic [7:0]    r_tx_shift;
    logic          r_tx_bit;
    logic          r_t;          // pad buffer T: 1 = released
    logic          r_hold_full;
    logic [7:0]    r_hold_dat;
    logic [1:0]    r_sync;
    logic          r_s_prev;

    logic          w_pad_o;
    logic          w_s;
    logic          w_fall;

    // Bidirectional pad buffer (maps onto the ECP5 BB: T=r_t, I=r_tx_bit, O=w_pad_o).
    assign line    = r_t ? 1'bz : r_tx_bit;
    assign w_pad_o = line;

    assign w_s    = r_sync[1];
    assign w_fall = r_s_prev & ~w_s;

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign tx_ready    = ~r_hold_full;
    assign busy        = ~r_t;

    // Two-flop synchronizer plus previous-value register for edge detection.
    // Resets to the idle-high level so reset release never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_s_prev <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], w_pad_o};
            r_s_prev <= w_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_bit      <= 1'b1;
            r_t           <= 1'b1;
            r_hold_full   <= 1'b0;
            r_hold_dat    <= '0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_cnt         <= r_cnt + 1'b1;

            // Load and clear of the holding register are mutually exclusive:
            // a load needs it empty, the clear below needs it full.
            if (tx_valid && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_dat  <= tx_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_RX_START;
                        r_cnt   <= '0;
                    end
                end

                ST_RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        r_state <= w_s ? ST_IDLE : ST_RX_DATA;
                    end
                end

                ST_RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt      <= '0;
                        r_rx_shift <= {w_s, r_rx_shift[7:1]};
                        r_bit      <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_RX_STOP;
                        end
                    end
                end

                ST_RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_s) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= ST_TURN;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= ST_IDLE;
                        end
                    end
                end

                ST_TURN: begin
                    if (w_fall) begin
                        // Initiator started another frame; keep any pending reply.
                        r_state <= ST_RX_START;
                        r_cnt   <= '0;
                    end else if (r_cnt == TURN_LAST) begin
                        r_cnt <= '0;
                        if (r_hold_full) begin
                            r_state     <= ST_TX_START;
                            r_t         <= 1'b0;
                            r_tx_bit    <= 1'b0;
                            r_tx_shift  <= r_hold_dat;
                            r_hold_full <= 1'b0;
                            r_bit       <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_TX_START: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt      <= '0;
                        r_tx_bit   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_state    <= ST_TX_DATA;
                    end
                end

                ST_TX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_tx_bit <= 1'b1;
                            r_state  <= ST_TX_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end
                end

                ST_TX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_t     <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_t     <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_responder.sv
// Purpose : self-checking bench for bidir_responder acting as the remote initiator.
// Latency : checks reply start TURN*CPB-1 cycles after the rx_valid strobe.
// Backpr. : replies offered only when tx_ready is high; every wait is cycle-bounded.
module tb_bidir_responder;

    localparam int C  = 12;
    localparam int TA = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tb_val = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       tx_ready;
    logic       busy;

    // Initiator drives the wire whenever the responder is not driving it.
    assign line = busy ? 1'bz : tb_val;

    bidir_responder #(
        .CLOCKS_PER_BIT (C),
        .TURNAROUND_BITS(TA)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .line       (line),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int   rv_count = 0;
    int   fe_count = 0;
    int   tx_count = 0;
    int   rv_cyc = 0;
    bit   abort_tx = 1'b0;

    // Output monitor, sampled on the falling edge.
    initial begin
        bit         prev_busy;
        bit         prev_ready;
        int         tx_run;
        logic [9:0] tx_bits;
        prev_busy  = 1'b0;
        prev_ready = 1'b1;
        tx_run     = 0;
        tx_bits    = '0;
        forever begin
            @(negedge clock);
            if (rx_valid) begin
                rv_count++;
                rv_cyc = cyc;
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no strobe", rx_data);
                end else begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
                end
            end
            if (frame_error) fe_count++;
            if (busy) begin
                if (!prev_busy) begin
                    tx_run = 0;
                    chk("tx_ready_rise", {30'd0, prev_ready, tx_ready}, 32'd1);
                    chk("turn_gap", cyc - rv_cyc, TA * C - 1);
                end
                if ((tx_run % C) == (C / 2) && tx_run < 10 * C) tx_bits[tx_run / C] = line;
                tx_run++;
            end else if (prev_busy && !abort_tx) begin
                tx_count++;
                chk("tx_len", tx_run, 10 * C);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got frame 0x%0h expected none", tx_bits);
                end else begin
                    chk("tx_frame", {22'd0, tx_bits}, {22'd0, 1'b1, exp_tx.pop_front(), 1'b0});
                end
            end
            prev_busy  = busy;
            prev_ready = tx_ready;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clock); #1;
        tb_val = 1'b0;
        repeat (C) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            tb_val = b[i];
            repeat (C) @(posedge clock);
            #1;
        end
        tb_val = stop;
        repeat (C) @(posedge clock);
        #1;
        tb_val = 1'b1;
    endtask

    task automatic queue_reply(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clock); #1;
        tx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat ((TA + 11) * C) @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [7:0] rx_byte;
        logic       stop;
        logic       q_reply;
        logic [7:0] reply;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_txv;
        logic [7:0] exp_txd;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         rv0, fe0, tx0, n;
        logic [7:0] exp_last;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
        exp_last = 8'h00;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_line", {31'd0, line}, 32'd1);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            rv0 = rv_count; fe0 = fe_count; tx0 = tx_count;
            if (vecs[v].q_reply) queue_reply(vecs[v].reply);
            if (vecs[v].exp_valid) begin
                exp_rx.push_back(vecs[v].rx_byte);
                exp_last = vecs[v].rx_byte;
            end
            if (vecs[v].exp_txv) exp_tx.push_back(vecs[v].exp_txd);
            send_frame(vecs[v].rx_byte, vecs[v].stop);
            settle();
            chk($sformatf("v%0d_rv_count", v), rv_count - rv0, {31'd0, vecs[v].exp_valid});
            chk($sformatf("v%0d_fe_count", v), fe_count - fe0, {31'd0, vecs[v].exp_fe});
            chk($sformatf("v%0d_tx_count", v), tx_count - tx0, {31'd0, vecs[v].exp_txv});
            chk($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, exp_last});
            chk($sformatf("v%0d_tx_ready", v), {31'd0, tx_ready}, {31'd0, vecs[v].exp_ready});
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_queues", v), exp_rx.size() + exp_tx.size(), 32'd0);
        end

        // 3-cycle low glitch on an idle line, then a normal frame
        rv0 = rv_count; fe0 = fe_count;
        @(posedge clock); #1;
        tb_val = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tb_val = 1'b1;
        repeat (3 * C) @(posedge clock);
        #1;
        chk("glitch_rv", rv_count - rv0, 32'd0);
        chk("glitch_fe", fe_count - fe0, 32'd0);
        exp_rx.push_back(8'h5A);
        exp_last = 8'h5A;
        send_frame(8'h5A, 1'b1);
        settle();
        chk("post_glitch_rv", rv_count - rv0, 32'd1);
        chk("post_glitch_rx_data", {24'd0, rx_data}, {24'd0, exp_last});

        // New frame starting during the turnaround; reply follows the second frame
        rv0 = rv_count; tx0 = tx_count;
        queue_reply(8'h3C);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        exp_tx.push_back(8'h3C);
        send_frame(8'h11, 1'b1);
        repeat (7) @(posedge clock);
        #1;
        chk("turn_busy_mid", {31'd0, busy}, 32'd0);
        send_frame(8'h22, 1'b1);
        settle();
        exp_last = 8'h22;
        chk("turn_rv", rv_count - rv0, 32'd2);
        chk("turn_tx", tx_count - tx0, 32'd1);
        chk("turn_rx_data", {24'd0, rx_data}, {24'd0, exp_last});
        chk("turn_queues", exp_rx.size() + exp_tx.size(), 32'd0);

        // Reset asserted during data bit 4 of a reply
        queue_reply(8'h5A);
        exp_rx.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        n = 0;
        while (!busy && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        chk("rst_mid_busy_wait", {31'd0, busy}, 32'd1);
        repeat (5 * C + C / 2) @(posedge clock);
        #1;
        chk("rst_mid_driving", {31'd0, busy}, 32'd1);
        abort_tx = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_mid_line", {31'd0, line}, 32'd1);
        chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        abort_tx = 1'b0;
        rv0 = rv_count; tx0 = tx_count;
        exp_rx.push_back(8'h44);
        send_frame(8'h44, 1'b1);
        settle();
        chk("post_rst_rv", rv_count - rv0, 32'd1);
        chk("post_rst_tx", tx_count - tx0, 32'd0);
        chk("post_rst_rx_data", {24'd0, rx_data}, 32'h44);
        chk("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("final_queues", exp_rx.size() + exp_tx.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
